// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a one-entry skid buffer.
// The skid buffer lets in_ready be registered. The block also has a sync flush and a saturating stall counter.
module pipe_stage_skid #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cycles
);

    // State encoding equals the number of words held, so occupancy is the state itself.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        MAIN_HOLD,
        MAIN_LOAD_IN,
        MAIN_LOAD_SKID,
        MAIN_BUBBLE,
        MAIN_CLEAR
    } main_op_t;

    typedef enum logic [1:0] {
        SKID_HOLD,
        SKID_LOAD_IN,
        SKID_CLEAR
    } skid_op_t;

    // Handshake: a word moves across a port on a rising edge where valid and ready are both 1.
    // Ready and valid are both registered here, so neither depends on a same-cycle input.
    state_t            r_state;
    state_t            w_next_state;
    main_op_t          w_main_op;
    skid_op_t          w_skid_op;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [CNT_W-1:0]  r_stall;
    logic              w_acc;
    logic              w_take;

    assign w_acc  = in_valid & r_in_ready;
    assign w_take = r_out_valid & out_ready;

    always_comb begin
        w_next_state = r_state;
        w_main_op    = MAIN_HOLD;
        w_skid_op    = SKID_HOLD;
        if (flush) begin
            w_next_state = ST_EMPTY;
            w_main_op    = MAIN_CLEAR;
            w_skid_op    = SKID_CLEAR;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_acc) begin
                        w_next_state = ST_ONE;
                        w_main_op    = MAIN_LOAD_IN;
                    end
                end
                ST_ONE: begin
                    if (w_acc && w_take) begin
                        w_main_op = MAIN_LOAD_IN;
                    end else if (w_acc) begin
                        w_next_state = ST_TWO;
                        w_skid_op    = SKID_LOAD_IN;
                    end else if (w_take) begin
                        w_next_state = ST_EMPTY;
                        w_main_op    = MAIN_BUBBLE;
                    end
                end
                ST_TWO: begin
                    if (w_take) begin
                        w_next_state = ST_ONE;
                        w_main_op    = MAIN_LOAD_SKID;
                        w_skid_op    = SKID_CLEAR;
                    end
                end
                default: begin
                    w_next_state = ST_EMPTY;
                    w_main_op    = MAIN_CLEAR;
                    w_skid_op    = SKID_CLEAR;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_in_ready  <= (w_next_state != ST_TWO);
            r_out_valid <= (w_next_state != ST_EMPTY);
        end
    end

    // A bubble only zeroes control bits; the payload is left as it was.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main_data <= '0;
            r_main_ctrl <= '0;
        end else begin
            case (w_main_op)
                MAIN_LOAD_IN: begin
                    r_main_data <= in_data;
                    r_main_ctrl <= in_ctrl;
                end
                MAIN_LOAD_SKID: begin
                    r_main_data <= r_skid_data;
                    r_main_ctrl <= r_skid_ctrl;
                end
                MAIN_BUBBLE: r_main_ctrl <= '0;
                MAIN_CLEAR: begin
                    r_main_data <= '0;
                    r_main_ctrl <= '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
        end else begin
            case (w_skid_op)
                SKID_LOAD_IN: begin
                    r_skid_data <= in_data;
                    r_skid_ctrl <= in_ctrl;
                end
                SKID_CLEAR: begin
                    r_skid_data <= '0;
                    r_skid_ctrl <= '0;
                end
                default: ;
            endcase
        end
    end

    // Flush deliberately leaves the stall counter alone; only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall <= '0;
        end else if (r_out_valid && !out_ready && (r_stall != {CNT_W{1'b1}})) begin
            r_stall <= r_stall + CNT_W'(1);
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign out_data     = r_main_data;
    assign out_ctrl     = r_main_ctrl;
    assign occupancy    = r_state;
    assign stall_cycles = r_stall;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid.
// A negedge monitor with an expected-word queue runs alongside the per-cycle hand checks.
module tb_pipe_stage_skid;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 8;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cycles;

    int n_checks = 0;
    int n_pass   = 0;
    logic [DATA_W+CTRL_W-1:0] exp_q[$];

    pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_ctrl      (in_ctrl),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_ctrl     (out_ctrl),
        .occupancy    (occupancy),
        .stall_cycles (stall_cycles)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                         input logic ordy);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
    endtask

    task automatic do_reset();
        drive(1'b0, '0, '0, 1'b0);
        flush = 1'b0;
        reset = 1'b1;
        exp_q.delete();
        repeat (2) cyc();
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_occupancy", {62'd0, occupancy}, 64'd0);
        check("rst_stall", {60'd0, stall_cycles}, 64'd0);
        check("rst_out_data", {32'd0, out_data}, 64'd0);
        reset = 1'b0;
        #1;
        check("rst_in_ready_low", {63'd0, in_ready}, 64'd0);
        cyc();
        check("in_ready_after_edge", {63'd0, in_ready}, 64'd1);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!reset) begin
            if (!out_valid) check("bubble_ctrl", {56'd0, out_ctrl}, 64'd0);
            if (out_valid && out_ready) begin
                check("sb_nonempty", {63'd0, exp_q.size() != 0}, 64'd1);
                if (exp_q.size() != 0)
                    check("sb_word", {24'd0, out_ctrl, out_data}, {24'd0, exp_q.pop_front()});
            end
            if (flush) exp_q.delete();
            else if (in_valid && in_ready) exp_q.push_back({in_ctrl, in_data});
        end
    end

    // ---------------- directed tests ----------------
    initial begin
        drive(1'b0, '0, '0, 1'b0);
        flush = 1'b0;
        reset = 1'b1;

        // Stream 1..8 with downstream always ready.
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, DATA_W'(i), CTRL_W'(i), 1'b1);
            cyc();
            check("stream_data", {32'd0, out_data}, 64'(i));
            check("stream_valid", {63'd0, out_valid}, 64'd1);
            check("stream_occ", {62'd0, occupancy}, 64'd1);
        end
        drive(1'b0, '0, '0, 1'b1);
        cyc();
        check("stream_end_valid", {63'd0, out_valid}, 64'd0);
        check("stream_stall", {60'd0, stall_cycles}, 64'd0);

        // Backpressure: A appears, downstream stalls three cycles.
        do_reset();
        drive(1'b1, 32'hA, 8'h1, 1'b0);
        cyc();
        check("bp_a_out", {32'd0, out_data}, 64'hA);
        drive(1'b1, 32'hB, 8'h2, 1'b0);
        cyc();
        check("bp_occ2", {62'd0, occupancy}, 64'd2);
        check("bp_in_ready0", {63'd0, in_ready}, 64'd0);
        drive(1'b1, 32'hC, 8'h3, 1'b0);
        cyc();
        cyc();
        check("bp_stall3", {60'd0, stall_cycles}, 64'd3);
        check("bp_hold_a", {32'd0, out_data}, 64'hA);
        drive(1'b1, 32'hC, 8'h3, 1'b1);
        cyc();
        check("bp_b_out", {32'd0, out_data}, 64'hB);
        check("bp_in_ready1", {63'd0, in_ready}, 64'd1);
        check("bp_occ1", {62'd0, occupancy}, 64'd1);
        cyc();
        check("bp_c_out", {32'd0, out_data}, 64'hC);
        drive(1'b0, '0, '0, 1'b1);
        cyc();
        check("bp_drained", {63'd0, out_valid}, 64'd0);
        check("bp_stall_final", {60'd0, stall_cycles}, 64'd3);

        // Flush while TWO with ctrl=0xFF.
        do_reset();
        drive(1'b1, 32'h11, 8'hFF, 1'b0);
        cyc();
        drive(1'b1, 32'h22, 8'hFF, 1'b0);
        cyc();
        check("fl_occ2", {62'd0, occupancy}, 64'd2);
        check("fl_ctrl_ff", {56'd0, out_ctrl}, 64'hFF);
        drive(1'b1, 32'h33, 8'hFF, 1'b0);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        check("fl_valid0", {63'd0, out_valid}, 64'd0);
        check("fl_ctrl0", {56'd0, out_ctrl}, 64'd0);
        check("fl_data0", {32'd0, out_data}, 64'd0);
        check("fl_occ0", {62'd0, occupancy}, 64'd0);
        check("fl_in_ready1", {63'd0, in_ready}, 64'd1);
        // Flush from ONE while the offered word is handshaken: it is discarded.
        drive(1'b1, 32'h44, 8'h4, 1'b0);
        cyc();
        drive(1'b1, 32'h55, 8'h5, 1'b1);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        drive(1'b0, '0, '0, 1'b1);
        check("fl1_valid0", {63'd0, out_valid}, 64'd0);
        cyc();
        check("fl1_no_reappear", {63'd0, out_valid}, 64'd0);

        // Drain bubble: ctrl zeroed, payload retained.
        do_reset();
        drive(1'b1, 32'h77, 8'h5A, 1'b1);
        cyc();
        check("db_ctrl", {56'd0, out_ctrl}, 64'h5A);
        drive(1'b0, '0, '0, 1'b1);
        cyc();
        check("db_valid0", {63'd0, out_valid}, 64'd0);
        check("db_ctrl0", {56'd0, out_ctrl}, 64'd0);
        check("db_data_kept", {32'd0, out_data}, 64'h77);

        // Stall counter saturation at 15.
        do_reset();
        drive(1'b1, 32'h99, 8'h9, 1'b0);
        cyc();
        drive(1'b0, '0, '0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            cyc();
            check("sat_count", {60'd0, stall_cycles}, (i < 15) ? 64'(i) : 64'd15);
        end
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        check("sat_flush_keep", {60'd0, stall_cycles}, 64'd15);
        check("sat_flush_valid0", {63'd0, out_valid}, 64'd0);
        cyc();
        check("sat_still15", {60'd0, stall_cycles}, 64'd15);
        do_reset();

        // Asynchronous reset pulse between edges while TWO.
        drive(1'b1, 32'hD1, 8'h1, 1'b0);
        cyc();
        drive(1'b1, 32'hD2, 8'h2, 1'b0);
        cyc();
        check("ar_occ2", {62'd0, occupancy}, 64'd2);
        drive(1'b0, '0, '0, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        check("ar_valid0", {63'd0, out_valid}, 64'd0);
        check("ar_ready0", {63'd0, in_ready}, 64'd0);
        check("ar_occ0", {62'd0, occupancy}, 64'd0);
        check("ar_data0", {32'd0, out_data}, 64'd0);
        check("ar_ctrl0", {56'd0, out_ctrl}, 64'd0);
        check("ar_stall0", {60'd0, stall_cycles}, 64'd0);
        #1;
        reset = 1'b0;
        exp_q.delete();
        #1;
        check("ar_ready_still0", {63'd0, in_ready}, 64'd0);
        cyc();
        check("ar_ready_rise", {63'd0, in_ready}, 64'd1);
        check("ar_valid_still0", {63'd0, out_valid}, 64'd0);

        cyc();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
